// File: rtl/devil_test_sequencer.sv
// Test-table sequencer for the devil snoop engine: arms one entry at a time,
// counts engine replies, and guards every wait with a watchdog and an abort.
module devil_test_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DEVIL_EN = 10,
  parameter int unsigned TIMEOUT  = 1024,
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              ace_aclk,
  input  logic              ace_areset,
  input  logic              i_cfg_we,
  input  logic [IDX_W-1:0]  i_cfg_idx,
  input  logic [31:0]       i_cfg_entry,
  input  logic [CNT_W-1:0]  i_num_entries,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [3:0]        i_fsm_devil_state,
  output logic [3:0]        o_snoop_state,
  output logic [31:0]       o_control_reg,
  output logic [31:0]       o_delay_reg,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout_err,
  output logic [IDX_W-1:0]  o_cur_idx,
  output logic [7:0]        o_reply_cnt
);

  localparam int unsigned WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned IDXP_W = IDX_W + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_ARM       = 3'd2;
  localparam logic [2:0] S_WAIT_RESP = 3'd3;
  localparam logic [2:0] S_WAIT_RET  = 3'd4;
  localparam logic [2:0] S_NEXT      = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_ERR       = 3'd7;

  localparam logic [3:0] DEV_IDLE  = 4'd0;
  localparam logic [3:0] DEV_CDLY  = 4'd2;
  localparam logic [3:0] DEV_RESP  = 4'd3;

  logic [31:0]      r_table [DEPTH];
  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_count;
  logic [WD_W-1:0]  r_wdog;
  logic [7:0]       r_reply_cnt;
  logic [7:0]       r_rep;
  logic             r_cont;
  logic [31:0]      r_control;
  logic [31:0]      r_delay;
  logic [3:0]       r_snoop;
  logic             r_busy;
  logic             r_done;
  logic             r_terr;

  logic [31:0]      w_entry;
  logic             w_entry_cont;
  logic             w_wd_hit;
  logic             w_last;
  logic [CNT_W-1:0] w_num_clamp;

  assign w_entry      = r_table[r_idx];
  assign w_entry_cont = (w_entry[7:4] == 4'd1);
  assign w_wd_hit     = (r_wdog == WD_W'(TIMEOUT - 1));
  assign w_last       = (CNT_W'(r_idx) == (r_count - CNT_W'(1)));
  assign w_num_clamp  = (i_num_entries > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : i_num_entries;

  // Table is writable only while idle; contents survive reset.
  always_ff @(posedge ace_aclk) begin
    if (i_cfg_we && (r_state == S_IDLE) && ({1'b0, i_cfg_idx} < IDXP_W'(DEPTH))) begin
      r_table[i_cfg_idx] <= i_cfg_entry;
    end
  end

  always_ff @(posedge ace_aclk) begin
    if (ace_areset) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next state; abort overrides everything, timeout overrides engine progress.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = (i_num_entries == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: w_next = S_ARM;
      S_ARM:  w_next = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (w_wd_hit)                              w_next = S_ERR;
        else if (i_fsm_devil_state == DEV_RESP)    w_next = S_WAIT_RET;
      end
      S_WAIT_RET: begin
        if (w_wd_hit) begin
          w_next = S_ERR;
        end else if (!r_cont) begin
          if (i_fsm_devil_state == DEV_IDLE) w_next = S_NEXT;
        end else if ((i_fsm_devil_state == DEV_CDLY) || (i_fsm_devil_state == DEV_IDLE)) begin
          w_next = (r_reply_cnt >= r_rep) ? S_NEXT : S_WAIT_RESP;
        end
      end
      S_NEXT:  w_next = w_last ? S_DONE : S_LOAD;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (i_abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge ace_aclk) begin
    if (ace_areset) begin
      r_idx       <= '0;
      r_count     <= '0;
      r_wdog      <= '0;
      r_reply_cnt <= '0;
      r_rep       <= 8'd1;
      r_cont      <= 1'b0;
      r_control   <= '0;
      r_delay     <= '0;
      r_snoop     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_terr      <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);

      if (w_next != r_state)                                        r_wdog <= '0;
      else if ((r_state == S_WAIT_RESP) || (r_state == S_WAIT_RET)) r_wdog <= r_wdog + WD_W'(1);

      case (r_state)
        S_IDLE: begin
          if (i_start && (i_num_entries != '0)) begin
            r_terr  <= 1'b0;
            r_idx   <= '0;
            r_count <= w_num_clamp;
          end
        end
        // Outputs load on the way into S_ARM so they are visible during S_ARM.
        S_LOAD: begin
          r_reply_cnt <= '0;
          r_cont      <= w_entry_cont;
          r_rep       <= (w_entry[15:8] == 8'd0) ? 8'd1 : w_entry[15:8];
          r_control   <= {14'd0, w_entry_cont, ~w_entry_cont, 7'd0,
                          w_entry[7:4], w_entry[3:0], 1'b0};
          r_delay     <= {16'd0, w_entry[31:16]};
          r_snoop     <= 4'(DEVIL_EN);
        end
        S_WAIT_RESP: begin
          if ((w_next == S_WAIT_RET) && (r_reply_cnt != 8'hFF)) r_reply_cnt <= r_reply_cnt + 8'd1;
        end
        S_NEXT: begin
          if (w_next == S_LOAD) r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase

      if (w_next == S_ERR) r_terr <= 1'b1;

      if (w_next == S_NEXT) begin
        r_control[17:16] <= 2'b00;
        r_snoop          <= '0;
      end

      if ((w_next == S_IDLE) || (w_next == S_ERR)) begin
        r_control <= '0;
        r_delay   <= '0;
        r_snoop   <= '0;
      end
    end
  end

  assign o_snoop_state = r_snoop;
  assign o_control_reg = r_control;
  assign o_delay_reg   = r_delay;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_timeout_err = r_terr;
  assign o_cur_idx     = r_idx;
  assign o_reply_cnt   = r_reply_cnt;

endmodule

// File: tb/tb_devil_test_sequencer.sv
// Scoreboard bench for devil_test_sequencer: completion records are queued at
// start and checked when o_done fires; the devil engine is driven by tasks.
module tb_devil_test_sequencer;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned DEVIL_EN = 10;
  localparam int unsigned TIMEOUT  = 16;

  logic        ace_aclk = 1'b0;
  logic        ace_areset;
  logic        i_cfg_we;
  logic [1:0]  i_cfg_idx;
  logic [31:0] i_cfg_entry;
  logic [2:0]  i_num_entries;
  logic        i_start;
  logic        i_abort;
  logic [3:0]  i_fsm_devil_state;
  logic [3:0]  o_snoop_state;
  logic [31:0] o_control_reg;
  logic [31:0] o_delay_reg;
  logic        o_busy;
  logic        o_done;
  logic        o_timeout_err;
  logic [1:0]  o_cur_idx;
  logic [7:0]  o_reply_cnt;

  devil_test_sequencer #(.DEPTH(DEPTH), .DEVIL_EN(DEVIL_EN), .TIMEOUT(TIMEOUT)) dut (
    .ace_aclk(ace_aclk), .ace_areset(ace_areset),
    .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx), .i_cfg_entry(i_cfg_entry),
    .i_num_entries(i_num_entries), .i_start(i_start), .i_abort(i_abort),
    .i_fsm_devil_state(i_fsm_devil_state),
    .o_snoop_state(o_snoop_state), .o_control_reg(o_control_reg), .o_delay_reg(o_delay_reg),
    .o_busy(o_busy), .o_done(o_done), .o_timeout_err(o_timeout_err),
    .o_cur_idx(o_cur_idx), .o_reply_cnt(o_reply_cnt)
  );

  always #5 ace_aclk = ~ace_aclk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  q_reply [$];
  logic [1:0]  q_idx [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk_entry(input int func, input int mode, input int rep, input int dly);
    return {16'(dly), 8'(rep), 4'(mode), 4'(func)};
  endfunction

  function automatic logic [31:0] exp_ctrl(input logic [31:0] e);
    logic cont;
    cont = (e[7:4] == 4'd1);
    return {14'd0, cont, !cont, 7'd0, e[7:4], e[3:0], 1'b0};
  endfunction

  // Every o_done must match a queued completion record.
  always @(negedge ace_aclk) begin
    if (o_done) begin
      if (q_reply.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        chk("done_reply", o_reply_cnt, q_reply.pop_front());
        chk("done_idx", o_cur_idx, q_idx.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge ace_aclk);
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] e);
    i_cfg_we = 1'b1; i_cfg_idx = 2'(idx); i_cfg_entry = e;
    tick();
    i_cfg_we = 1'b0;
  endtask

  task automatic start_run(input int num, input bit expect_done, input int rep, input int idx);
    if (expect_done) begin
      q_reply.push_back(8'(rep));
      q_idx.push_back(2'(idx));
    end
    i_num_entries = 3'(num); i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl_dly"}, {o_control_reg, o_delay_reg}, 64'd0);
    chk({tag, "_misc"}, {o_snoop_state, o_cur_idx, o_reply_cnt, o_busy, o_done, o_timeout_err}, 64'd0);
  endtask

  // Waits for the ARM cycle, checks armed outputs, then steps into S_WAIT_RESP.
  task automatic wait_arm(input string tag, input logic [31:0] e, input int idx);
    int n = 0;
    while ((o_snoop_state != 4'(DEVIL_EN)) && (n < 8)) begin tick(); n++; end
    chk({tag, "_arm_snoop"}, o_snoop_state, DEVIL_EN);
    chk({tag, "_arm_ctrl"}, o_control_reg, exp_ctrl(e));
    chk({tag, "_arm_dly"}, o_delay_reg, {48'd0, e[31:16]});
    chk({tag, "_arm_idx"}, o_cur_idx, idx);
    tick();
  endtask

  // Devil engine model: RESPONSE then return (0 one-shot, 2 continuous).
  task automatic serve(input string tag, input bit cont, input int reps);
    for (int i = 0; i < reps; i++) begin
      i_fsm_devil_state = 4'd3;
      tick();
      chk({tag, "_rcnt"}, o_reply_cnt, i + 1);
      i_fsm_devil_state = cont ? 4'd2 : 4'd0;
      tick();
      if (i < reps - 1) begin
        chk({tag, "_hold_en"}, o_control_reg[17:16], 2'b10);
        chk({tag, "_hold_snoop"}, o_snoop_state, DEVIL_EN);
      end
    end
    chk({tag, "_next_en"}, o_control_reg[17:16], 0);
    chk({tag, "_next_snoop"}, o_snoop_state, 0);
    i_fsm_devil_state = 4'd0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy && (n < 40)) begin tick(); n++; end
    chk({tag, "_idle"}, o_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] e0, e1, ent;
    ace_areset = 1'b1; i_cfg_we = 1'b0; i_cfg_idx = '0; i_cfg_entry = '0;
    i_num_entries = '0; i_start = 1'b0; i_abort = 1'b0; i_fsm_devil_state = '0;
    tick(); tick();
    chk_zero("reset");
    ace_areset = 1'b0;
    tick();

    // One-shot single entry
    e0 = mk_entry(3, 0, 1, 1);
    cfg_write(0, e0);
    start_run(1, 1, 1, 0);
    chk("t1_busy", o_busy, 1);
    tick();
    chk("t1_ctrl_const", o_control_reg, 32'h0001_0006);
    wait_arm("t1", e0, 0);
    serve("t1", 1'b0, 1);
    tick();
    chk("t1_done", o_done, 1);
    tick();
    chk("t1_done_once", o_done, 0);
    chk("t1_idle_busy", o_busy, 0);
    chk("t1_idle_ctl", {o_control_reg, o_delay_reg}, 64'd0);

    // Continuous, five replies
    e0 = mk_entry(1, 1, 5, 2);
    cfg_write(0, e0);
    start_run(1, 1, 5, 0);
    wait_arm("t2", e0, 0);
    serve("t2", 1'b1, 5);
    wait_idle("t2");

    // One-shot (mode 5) then continuous rep 2
    e0 = mk_entry(5, 5, 1, 7);
    e1 = mk_entry(9, 1, 2, 16'h1234);
    cfg_write(0, e0);
    cfg_write(1, e1);
    start_run(2, 1, 2, 1);
    wait_arm("t3a", e0, 0);
    serve("t3a", 1'b0, 1);
    chk("t3_next_busy", o_busy, 1);
    wait_arm("t3b", e1, 1);
    chk("t3b_ctrl_const", o_control_reg, 32'h0002_0032);
    serve("t3b", 1'b1, 2);
    wait_idle("t3");

    // Count above DEPTH clamps; rep 0 acts as 1; mode 7 is one-shot
    for (int i = 0; i < 4; i++) cfg_write(i, mk_entry(i + 1, (i == 3) ? 7 : 1, 0, 16'h100 + i));
    start_run(7, 1, 1, 3);
    for (int i = 0; i < 4; i++) begin
      ent = mk_entry(i + 1, (i == 3) ? 7 : 1, 0, 16'h100 + i);
      wait_arm("t4", ent, i);
      serve("t4", i != 3, 1);
    end
    wait_idle("t4");

    // Watchdog with the engine stuck at IDLE
    e0 = mk_entry(2, 0, 1, 3);
    cfg_write(0, e0);
    start_run(1, 0, 0, 0);
    wait_arm("t5", e0, 0);
    repeat (TIMEOUT - 1) tick();
    chk("t5_err_early", o_timeout_err, 0);
    tick();
    chk("t5_err_set", o_timeout_err, 1);
    chk("t5_err_zero", {o_control_reg, o_delay_reg, 28'd0, o_snoop_state}, 96'd0);
    tick();
    chk("t5_idle_busy", o_busy, 0);
    chk("t5_sticky", o_timeout_err, 1);
    start_run(1, 1, 1, 0);
    chk("t5_err_clear", o_timeout_err, 0);
    wait_arm("t5b", e0, 0);
    serve("t5b", 1'b0, 1);
    wait_idle("t5b");

    // Abort in S_WAIT_RET coinciding with the watchdog limit
    start_run(1, 0, 0, 0);
    wait_arm("t6", e0, 0);
    i_fsm_devil_state = 4'd3;
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("t6_pre_abort_busy", o_busy, 1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0; i_fsm_devil_state = 4'd0;
    chk("t6_abort_ctl", {o_control_reg, o_delay_reg}, 64'd0);
    chk("t6_abort_misc", {o_snoop_state, o_busy, o_done, o_timeout_err}, 0);
    repeat (3) tick();
    start_run(0, 1, 1, 0);
    chk("t6_zero_done", o_done, 1);
    tick();
    chk("t6_zero_done_once", o_done, 0);

    // Reset during S_WAIT_RESP, then writes while busy are dropped
    start_run(1, 0, 0, 0);
    wait_arm("t7", e0, 0);
    ace_areset = 1'b1;
    tick();
    chk_zero("t7_reset");
    ace_areset = 1'b0;
    tick();
    start_run(1, 1, 1, 0);
    cfg_write(0, 32'hFFFF_FFFF);
    wait_arm("t7a", e0, 0);
    serve("t7a", 1'b0, 1);
    wait_idle("t7a");
    start_run(1, 1, 1, 0);
    wait_arm("t7b", e0, 0);
    serve("t7b", 1'b0, 1);
    wait_idle("t7b");

    tick();
    chk("sb_empty", q_reply.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
